// File: rtl/wc_tile_sequencer.sv
// Command-driven operand loader and result drainer for the Winograd 5x5 core.
// Loads a resident 3x3 kernel and 5x5 tiles, starts the core, and streams 3x3 results out.
module wc_tile_sequencer #(
   parameter int DW         = 10,
   parameter int TILE_WORDS = 25,
   parameter int KERN_WORDS = 9,
   parameter int OUT_WORDS  = 9,
   parameter int TIMEOUT    = 1023
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          core_we,
   output logic          core_sel,
   output logic [4:0]    core_addr,
   output logic [DW-1:0] core_wdata,
   output logic          core_start,
   input  logic          core_done,
   output logic [3:0]    core_raddr,
   input  logic [DW-1:0] core_rdata,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
   output logic          kern_loaded,
   output logic          err_cmd,
   output logic          err_timeout
);
   localparam int              TW        = $clog2(TIMEOUT + 1);
   localparam logic [DW-1:0]   CMD_KERN  = DW'(1);
   localparam logic [DW-1:0]   CMD_TILE  = DW'(2);
   localparam logic [4:0]      KERN_LAST = 5'(KERN_WORDS - 1);
   localparam logic [4:0]      TILE_LAST = 5'(TILE_WORDS - 1);
   localparam logic [3:0]      OUT_LAST  = 4'(OUT_WORDS - 1);
   localparam logic [TW-1:0]   TIMER_MAX = TW'(TIMEOUT);

   typedef enum logic [2:0] {
      S_HDR, S_LOAD_K, S_LOAD_T, S_START, S_WAIT, S_DRAIN
   } state_t;

   state_t        state_q, state_d;
   logic [4:0]    cnt_q, cnt_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0]    rcnt_q, rcnt_d;
   logic          rd_wait_q, rd_wait_d;
   logic          in_ready_q, in_ready_d;
   logic          core_we_q, core_we_d;
   logic          core_sel_q, core_sel_d;
   logic [4:0]    core_addr_q, core_addr_d;
   logic [DW-1:0] core_wdata_q, core_wdata_d;
   logic          core_start_q, core_start_d;
   logic [3:0]    core_raddr_q, core_raddr_d;
   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic          kern_loaded_q, kern_loaded_d;
   logic          err_cmd_q, err_cmd_d;
   logic          err_timeout_q, err_timeout_d;
   logic          accept;

   assign accept = in_valid && in_ready_q;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      timer_d       = timer_q;
      rcnt_d        = rcnt_q;
      rd_wait_d     = rd_wait_q;
      core_we_d     = 1'b0;
      core_sel_d    = core_sel_q;
      core_addr_d   = core_addr_q;
      core_wdata_d  = core_wdata_q;
      core_start_d  = 1'b0;
      core_raddr_d  = core_raddr_q;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      kern_loaded_d = kern_loaded_q;
      err_cmd_d     = err_cmd_q;
      err_timeout_d = err_timeout_q;

      case (state_q)
         S_HDR: begin
            if (accept) begin
               if (in_data == CMD_KERN) begin
                  state_d       = S_LOAD_K;
                  cnt_d         = 5'd0;
                  kern_loaded_d = 1'b0;
               end else if (in_data == CMD_TILE) begin
                  state_d = S_LOAD_T;
                  cnt_d   = 5'd0;
               end else begin
                  err_cmd_d = 1'b1;
               end
            end
         end
         S_LOAD_K, S_LOAD_T: begin
            if (accept) begin
               core_we_d    = 1'b1;
               core_sel_d   = (state_q == S_LOAD_K);
               core_addr_d  = cnt_q;
               core_wdata_d = in_data;
               cnt_d        = cnt_q + 5'd1;
               if (state_q == S_LOAD_K && cnt_q == KERN_LAST) begin
                  kern_loaded_d = 1'b1;
                  state_d       = S_HDR;
               end else if (state_q == S_LOAD_T && cnt_q == TILE_LAST) begin
                  state_d = S_START;
               end
            end
         end
         S_START: begin
            if (kern_loaded_q) begin
               core_start_d = 1'b1;
               timer_d      = '0;
               state_d      = S_WAIT;
            end else begin
               err_cmd_d = 1'b1;
               state_d   = S_HDR;
            end
         end
         S_WAIT: begin
            if (core_done) begin
               state_d      = S_DRAIN;
               rcnt_d       = 4'd0;
               core_raddr_d = 4'd0;
               rd_wait_d    = 1'b1;
            end else if (timer_q == TIMER_MAX) begin
               err_timeout_d = 1'b1;
               state_d       = S_HDR;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_DRAIN: begin
            // Address is advanced at capture so the next word's read latency
            // overlaps the current word's handshake.
            if (rd_wait_q) begin
               rd_wait_d = 1'b0;
            end else if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_data_d  = core_rdata;
               if (rcnt_q != OUT_LAST) core_raddr_d = rcnt_q + 4'd1;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               rcnt_d      = rcnt_q + 4'd1;
               if (rcnt_q == OUT_LAST) state_d = S_HDR;
            end
         end
         default: state_d = S_HDR;
      endcase

      in_ready_d = (state_d == S_HDR) || (state_d == S_LOAD_K) || (state_d == S_LOAD_T);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_HDR;
         cnt_q         <= '0;
         timer_q       <= '0;
         rcnt_q        <= '0;
         rd_wait_q     <= 1'b0;
         in_ready_q    <= 1'b0;
         core_we_q     <= 1'b0;
         core_sel_q    <= 1'b0;
         core_addr_q   <= '0;
         core_wdata_q  <= '0;
         core_start_q  <= 1'b0;
         core_raddr_q  <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         kern_loaded_q <= 1'b0;
         err_cmd_q     <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         timer_q       <= timer_d;
         rcnt_q        <= rcnt_d;
         rd_wait_q     <= rd_wait_d;
         in_ready_q    <= in_ready_d;
         core_we_q     <= core_we_d;
         core_sel_q    <= core_sel_d;
         core_addr_q   <= core_addr_d;
         core_wdata_q  <= core_wdata_d;
         core_start_q  <= core_start_d;
         core_raddr_q  <= core_raddr_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         kern_loaded_q <= kern_loaded_d;
         err_cmd_q     <= err_cmd_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign core_we     = core_we_q;
   assign core_sel    = core_sel_q;
   assign core_addr   = core_addr_q;
   assign core_wdata  = core_wdata_q;
   assign core_start  = core_start_q;
   assign core_raddr  = core_raddr_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign kern_loaded = kern_loaded_q;
   assign err_cmd     = err_cmd_q;
   assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_wc_tile_sequencer.sv
// Directed bench for wc_tile_sequencer: queued expected writes/results checked as the DUT emits them.
module tb_wc_tile_sequencer;
   localparam int DW      = 10;
   localparam int TIMEOUT = 1023;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          core_we;
   logic          core_sel;
   logic [4:0]    core_addr;
   logic [DW-1:0] core_wdata;
   logic          core_start;
   logic          core_done = 1'b0;
   logic [3:0]    core_raddr;
   logic [DW-1:0] core_rdata = '0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;
   logic          kern_loaded;
   logic          err_cmd;
   logic          err_timeout;

   wc_tile_sequencer #(
      .DW(DW), .TILE_WORDS(25), .KERN_WORDS(9), .OUT_WORDS(9), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .core_we(core_we), .core_sel(core_sel), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_start(core_start), .core_done(core_done),
      .core_raddr(core_raddr), .core_rdata(core_rdata),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .kern_loaded(kern_loaded), .err_cmd(err_cmd), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   // Core model: registered read (rdata = raddr + 100), done 40 cycles after start when enabled.
   logic core_en = 1'b1;
   int   done_cnt = 0;
   always @(posedge clk) begin
      core_rdata <= DW'(core_raddr) + 10'd100;
      core_done  <= 1'b0;
      if (core_start && core_en) begin
         done_cnt <= 40;
      end else if (done_cnt > 0) begin
         done_cnt <= done_cnt - 1;
         if (done_cnt == 1) core_done <= 1'b1;
      end
   end

   typedef struct {
      logic          sel;
      logic [4:0]    addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t           wq[$];
   logic [DW-1:0] oq[$];
   int            vectors = 0;
   int            fails = 0;
   int            cyc = 0;
   int            last_we_cyc = -100;
   int            start_cyc = 0;
   int            start_count = 0;
   int            xfer_idx = 0;
   int            prev_xfer = 0;
   bit            rate_check = 1'b0;
   bit            ready_mode = 1'b0;
   bit            seen_out_valid = 1'b0;
   bit            prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic monitor();
      wr_t           e;
      logic [DW-1:0] eo;
      if (core_we === 1'b1) begin
         if (wq.size() == 0) begin
            check("we_unexpected", 32'(core_we), 32'd0);
         end else begin
            e = wq.pop_front();
            check("we_sel", 32'(core_sel), 32'(e.sel));
            check("we_addr", 32'(core_addr), 32'(e.addr));
            check("we_data", 32'(core_wdata), 32'(e.data));
         end
         last_we_cyc = cyc;
      end
      if (core_start === 1'b1) begin
         start_count++;
         start_cyc = cyc;
         check("start_after_last_we", 32'(cyc - last_we_cyc), 32'd1);
      end
      if (out_valid === 1'b1) seen_out_valid = 1'b1;
      if (prev_stall) begin
         check("stall_hold_valid", 32'(out_valid), 32'd1);
         check("stall_hold_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         if (oq.size() == 0) begin
            check("out_unexpected", 32'(out_valid), 32'd0);
         end else begin
            eo = oq.pop_front();
            $display("xfer %0d: out_data=%0d at cycle %0d", xfer_idx, out_data, cyc);
            check("out_data", 32'(out_data), 32'(eo));
         end
         if (rate_check && xfer_idx > 0) check("out_rate", 32'(cyc - prev_xfer), 32'd2);
         prev_xfer = cyc;
         xfer_idx++;
      end
      prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
      prev_data  = out_data;
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      out_ready = (ready_mode == 1'b0) ? 1'b1 : ((cyc % 3) == 0);
      monitor();
   endtask

   task automatic send_word(input logic [DW-1:0] w, input bit gap);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = w;
      while (in_ready !== 1'b1) begin
         if (n == 50) begin
            check("in_ready_wait", 32'(in_ready), 32'd1);
            break;
         end
         step();
         n++;
      end
      step();
      in_valid = 1'b0;
      if (gap) step();
   endtask

   task automatic send_tile(input bit gap);
      send_word(10'h002, 1'b0);
      for (int i = 0; i < 25; i++) begin
         wq.push_back('{sel: 1'b0, addr: 5'(i), data: DW'(i)});
         send_word(DW'(i), gap);
      end
   endtask

   task automatic send_kernel();
      send_word(10'h001, 1'b0);
      for (int i = 0; i < 9; i++) begin
         wq.push_back('{sel: 1'b1, addr: 5'(i), data: DW'(i + 1)});
         send_word(DW'(i + 1), 1'b0);
      end
   endtask

   task automatic push_results();
      for (int i = 0; i < 9; i++) oq.push_back(DW'(100 + i));
      xfer_idx    = 0;
      start_count = 0;
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (oq.size() != 0 && n < 400) begin
         step();
         n++;
      end
      check({tag, "_drain_left"}, 32'(oq.size()), 32'd0);
      check({tag, "_in_ready_last_xfer"}, 32'(in_ready), 32'd0);
      step();
      check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
      check({tag, "_xfers"}, 32'(xfer_idx), 32'd9);
      check({tag, "_starts"}, 32'(start_count), 32'd1);
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_core_we"}, 32'(core_we), 32'd0);
      check({tag, "_core_sel"}, 32'(core_sel), 32'd0);
      check({tag, "_core_addr"}, 32'(core_addr), 32'd0);
      check({tag, "_core_wdata"}, 32'(core_wdata), 32'd0);
      check({tag, "_core_start"}, 32'(core_start), 32'd0);
      check({tag, "_core_raddr"}, 32'(core_raddr), 32'd0);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_out_data"}, 32'(out_data), 32'd0);
      check({tag, "_kern_loaded"}, 32'(kern_loaded), 32'd0);
      check({tag, "_err_cmd"}, 32'(err_cmd), 32'd0);
      check({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
   endtask

   initial begin
      int n;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;

      // Power-on reset
      step();
      step();
      check_reset_outs("por");
      rst = 1'b1;
      step();
      check("in_ready_after_reset", 32'(in_ready), 32'd1);

      // Reset in the middle of a tile load
      send_word(10'h002, 1'b0);
      for (int i = 0; i < 12; i++) begin
         wq.push_back('{sel: 1'b0, addr: 5'(i), data: DW'(i + 200)});
         send_word(DW'(i + 200), 1'b0);
      end
      step();
      check("mid_load_writes_done", 32'(wq.size()), 32'd0);
      #2 rst = 1'b0;
      #1 check_reset_outs("mid_load");
      step();
      rst = 1'b1;
      step();

      // Tile with no kernel resident: no start, err_cmd
      start_count = 0;
      send_tile(1'b0);
      for (int i = 0; i < 5; i++) step();
      check("nokern_starts", 32'(start_count), 32'd0);
      check("nokern_err_cmd", 32'(err_cmd), 32'd1);
      check("nokern_in_ready", 32'(in_ready), 32'd1);
      check("nokern_writes_done", 32'(wq.size()), 32'd0);

      // Kernel then toggling-valid tile, out_ready always high
      send_kernel();
      step();
      check("kern_loaded_set", 32'(kern_loaded), 32'd1);
      push_results();
      rate_check = 1'b1;
      send_tile(1'b1);
      wait_drain("t1");
      rate_check = 1'b0;

      // Same kernel, out_ready every third cycle
      ready_mode = 1'b1;
      push_results();
      send_tile(1'b0);
      wait_drain("t2");
      ready_mode = 1'b0;

      // Fresh reset, kernel, then an illegal header
      rst = 1'b0;
      step();
      rst = 1'b1;
      step();
      check("rst2_err_cmd", 32'(err_cmd), 32'd0);
      send_kernel();
      send_word(10'h3FF, 1'b0);
      step();
      check("bad_hdr_err_cmd", 32'(err_cmd), 32'd1);
      check("bad_hdr_in_ready", 32'(in_ready), 32'd1);
      push_results();
      send_tile(1'b0);
      wait_drain("t3");

      // Core never finishes
      core_en        = 1'b0;
      start_count    = 0;
      seen_out_valid = 1'b0;
      send_tile(1'b0);
      n = 0;
      while (err_timeout !== 1'b1 && n < 1200) begin
         step();
         n++;
      end
      check("timeout_latency", 32'(cyc - start_cyc), 32'(TIMEOUT + 1));
      check("timeout_flag", 32'(err_timeout), 32'd1);
      check("timeout_starts", 32'(start_count), 32'd1);
      check("timeout_no_out", 32'(seen_out_valid), 32'd0);
      check("timeout_in_ready", 32'(in_ready), 32'd1);
      check("timeout_kern_kept", 32'(kern_loaded), 32'd1);
      check("final_writes_done", 32'(wq.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
